// File: rtl/spi_mem_ctrl_if.sv
// Signal bundle between an SPI master, the spi_mem_ctrl slave front end and the
// 8x128 data memory port it drives.
interface spi_mem_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              frame_done;

  modport slave (
    input  sclk, cs_n, mosi, mem_dout,
    output miso, miso_oe, mem_addr, mem_wren, mem_din, frame_done
  );

  modport master (
    output sclk, cs_n, mosi, mem_dout,
    input  miso, miso_oe, mem_addr, mem_wren, mem_din, frame_done
  );
endinterface

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 slave that turns 16-bit frames (7-bit address, R/W, data byte)
// into single read or write accesses on a synchronous data memory port.
module spi_mem_ctrl #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MEM_RD_LAT  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_mem_ctrl_if.slave bus
);

  localparam int CMD_W  = ADDR_W + 1;
  localparam int SR_W   = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
  localparam int CNT_W  = $clog2(((CMD_W > DATA_W) ? CMD_W : DATA_W) + 1);
  localparam int WAIT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE, GET_CMD, RD_WAIT, RD_LOAD, SEND, GET_DATA, WRITE, DONE
  } state_e;

  state_e                 state_q,      state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q,  sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,    cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q,  mosi_sync_d;
  logic                   sclk_prev_q,  sclk_prev_d;
  logic [CNT_W-1:0]       bit_cnt_q,    bit_cnt_d;
  logic [WAIT_W-1:0]      wait_cnt_q,   wait_cnt_d;
  logic [SR_W-1:0]        rx_q,         rx_d;
  logic [DATA_W-1:0]      tx_q,         tx_d;
  logic                   miso_q,       miso_d;
  logic                   miso_oe_q,    miso_oe_d;
  logic [ADDR_W-1:0]      mem_addr_q,   mem_addr_d;
  logic                   mem_wren_q,   mem_wren_d;
  logic [DATA_W-1:0]      mem_din_q,    mem_din_d;
  logic                   frame_done_q, frame_done_d;

  logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s &  sclk_prev_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0],   bus.cs_n};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    sclk_prev_d  = sclk_s;
    bit_cnt_d    = bit_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    miso_d       = miso_q;
    miso_oe_d    = miso_oe_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_wren_d   = 1'b0;
    frame_done_d = 1'b0;

    // Deselect wins over everything: a partial frame is simply abandoned.
    if (cs_s) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          state_d   = GET_CMD;
        end
        GET_CMD: if (sclk_rise) begin
          rx_d      = {rx_q[SR_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
            mem_addr_d = rx_q[ADDR_W-1:0];
            bit_cnt_d  = '0;
            wait_cnt_d = '0;
            state_d    = mosi_s ? RD_WAIT : GET_DATA;
          end
        end
        RD_WAIT: begin
          if (wait_cnt_q == WAIT_W'(MEM_RD_LAT - 1)) state_d = RD_LOAD;
          else                                       wait_cnt_d = wait_cnt_q + 1'b1;
        end
        RD_LOAD: begin
          tx_d      = bus.mem_dout;
          miso_oe_d = 1'b1;
          state_d   = SEND;
        end
        SEND: begin
          if (sclk_fall && bit_cnt_q != CNT_W'(DATA_W)) begin
            miso_d    = tx_q[DATA_W-1];
            tx_d      = {tx_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (sclk_rise && bit_cnt_q == CNT_W'(DATA_W)) begin
            // Master has sampled the last bit on this (16th) rise.
            miso_d       = 1'b0;
            miso_oe_d    = 1'b0;
            frame_done_d = 1'b1;
            state_d      = DONE;
          end
        end
        GET_DATA: if (sclk_rise) begin
          rx_d      = {rx_q[SR_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            mem_din_d    = {rx_q[DATA_W-2:0], mosi_s};
            mem_wren_d   = 1'b1;
            frame_done_d = 1'b1;
            state_d      = WRITE;
          end
        end
        WRITE:   state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sclk_sync_q  <= '0;
      cs_sync_q    <= '0;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      bit_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wren_q   <= 1'b0;
      mem_din_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      state_q      <= state_d;
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      mem_addr_q   <= mem_addr_d;
      mem_wren_q   <= mem_wren_d;
      mem_din_q    <= mem_din_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.miso       = miso_q;
  assign bus.miso_oe    = miso_oe_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wren   = mem_wren_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: a bit-banged SPI master plus a 1-cycle
// latency memory model; expected values are hand-computed per scenario.
module tb_spi_mem_ctrl;
  localparam int HALF = 10;  // sclk half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mem_ctrl_if bus ();

  spi_mem_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous memory, read latency 1; contents re-initialised while in reset.
  logic [7:0] mem [128];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= (i == 2) ? 8'hF0 : 8'h00;
      bus.mem_dout <= 8'h00;
    end else begin
      if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_din;
      bus.mem_dout <= mem[bus.mem_addr];
    end
  end

  // Activity monitor sampled away from the active edge.
  int         wren_cnt = 0;
  int         fd_cnt   = 0;
  int         oe_cnt   = 0;
  logic [6:0] wr_addr  = '0;
  logic [7:0] wr_din   = '0;
  always @(negedge clk) begin
    if (bus.mem_wren) begin
      wren_cnt <= wren_cnt + 1;
      wr_addr  <= bus.mem_addr;
      wr_din   <= bus.mem_din;
    end
    if (bus.frame_done) fd_cnt <= fd_cnt + 1;
    if (bus.miso_oe)    oe_cnt <= oe_cnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI frame of npulses sclk pulses; rdata collects MISO on rises 9..16,
  // oe_vec collects miso_oe just before each of the first 16 rises (MSB = rise 1).
  task automatic do_frame(input logic [6:0] addr, input logic rw, input logic [7:0] wdata,
                          input int npulses, input bit release_cs,
                          output logic [7:0] rdata, output logic [15:0] oe_vec);
    logic [15:0] bits;
    bits   = {addr, rw, wdata};
    rdata  = '0;
    oe_vec = '0;
    bus.cs_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < npulses; i++) begin
      bus.mosi = (i < 16) ? bits[15-i] : 1'b0;
      wait_clks(HALF);
      if (i < 16) oe_vec = {oe_vec[14:0], bus.miso_oe};
      if (i >= 8 && i < 16) rdata = {rdata[6:0], bus.miso};
      bus.sclk = 1'b1;
      wait_clks(HALF);
      bus.sclk = 1'b0;
    end
    wait_clks(HALF);
    if (release_cs) begin
      bus.cs_n = 1'b1;
      wait_clks(2 * HALF);
    end
  endtask

  task automatic write_frame(input string name, input logic [6:0] addr, input logic [7:0] data,
                             input int npulses);
    logic [7:0]  rd;
    logic [15:0] oe;
    int w0, f0, o0;
    w0 = wren_cnt; f0 = fd_cnt; o0 = oe_cnt;
    do_frame(addr, 1'b0, data, npulses, 1'b1, rd, oe);
    n_checks++;
    if (wren_cnt - w0 !== 1) $display("FAIL %s wren_cycles: got %0d expected 1", name, wren_cnt - w0);
    else n_pass++;
    n_checks++;
    if ({wr_addr, wr_din} !== {addr, data})
      $display("FAIL %s write_access: got addr %h din %h expected addr %h din %h", name, wr_addr, wr_din, addr, data);
    else n_pass++;
    n_checks++;
    if (fd_cnt - f0 !== 1) $display("FAIL %s frame_done_cycles: got %0d expected 1", name, fd_cnt - f0);
    else n_pass++;
    n_checks++;
    if (oe_cnt - o0 !== 0 || oe !== 16'h0000)
      $display("FAIL %s miso_oe_during_write: got %0d cycles expected 0", name, oe_cnt - o0);
    else n_pass++;
  endtask

  task automatic read_frame(input string name, input logic [6:0] addr, input logic [7:0] exp);
    logic [7:0]  rd;
    logic [15:0] oe;
    int w0, f0;
    w0 = wren_cnt; f0 = fd_cnt;
    do_frame(addr, 1'b1, 8'h00, 16, 1'b1, rd, oe);
    n_checks++;
    if (rd !== exp) $display("FAIL %s read_data: got %h expected %h", name, rd, exp);
    else n_pass++;
    n_checks++;
    if (oe !== 16'h00FF) $display("FAIL %s miso_oe_window: got %h expected 00ff", name, oe);
    else n_pass++;
    n_checks++;
    if (wren_cnt - w0 !== 0) $display("FAIL %s wren_during_read: got %0d expected 0", name, wren_cnt - w0);
    else n_pass++;
    n_checks++;
    if (fd_cnt - f0 !== 1) $display("FAIL %s frame_done_cycles: got %0d expected 1", name, fd_cnt - f0);
    else n_pass++;
    n_checks++;
    if (bus.miso_oe !== 1'b0) $display("FAIL %s miso_oe_after: got %b expected 0", name, bus.miso_oe);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clks(3);
    n_checks++;
    if ({bus.miso, bus.miso_oe, bus.mem_addr, bus.mem_wren, bus.mem_din, bus.frame_done} !== '0)
      $display("FAIL reset_outputs: got addr %h din %h wren %b fd %b oe %b miso %b expected all 0",
               bus.mem_addr, bus.mem_din, bus.mem_wren, bus.frame_done, bus.miso_oe, bus.miso);
    else n_pass++;
    rst_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic test_write();
    write_frame("write", 7'h01, 8'h5A, 16);
    n_checks++;
    if (bus.mem_addr !== 7'h01) $display("FAIL addr_hold: got %h expected 01", bus.mem_addr);
    else n_pass++;
  endtask

  task automatic test_read();
    read_frame("read_preload", 7'h02, 8'hF0);
  endtask

  task automatic test_write_then_read();
    write_frame("wtr_w1", 7'h01, 8'h5A, 16);
    write_frame("wtr_w2", 7'h02, 8'hF0, 16);
    write_frame("wtr_w3", 7'h55, 8'h3C, 16);
    read_frame("wtr_r1", 7'h01, 8'h5A);
    read_frame("wtr_r2", 7'h02, 8'hF0);
    read_frame("wtr_r3", 7'h55, 8'h3C);
  endtask

  task automatic test_abort();
    logic [7:0]  rd;
    logic [15:0] oe;
    int w0, f0;
    w0 = wren_cnt; f0 = fd_cnt;
    do_frame(7'h7F, 1'b0, 8'hA5, 12, 1'b1, rd, oe);
    n_checks++;
    if (wren_cnt - w0 !== 0) $display("FAIL abort_wren: got %0d expected 0", wren_cnt - w0);
    else n_pass++;
    n_checks++;
    if (fd_cnt - f0 !== 0) $display("FAIL abort_frame_done: got %0d expected 0", fd_cnt - f0);
    else n_pass++;
    write_frame("after_abort", 7'h10, 8'h81, 16);
  endtask

  task automatic test_reset_mid_read();
    logic [7:0]  rd;
    logic [15:0] oe;
    do_frame(7'h02, 1'b1, 8'h00, 12, 1'b0, rd, oe);
    n_checks++;
    if (bus.miso_oe !== 1'b1) $display("FAIL mid_read_oe: got %b expected 1", bus.miso_oe);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.miso, bus.miso_oe, bus.mem_addr, bus.mem_wren, bus.mem_din, bus.frame_done} !== '0)
      $display("FAIL async_reset_outputs: got addr %h din %h oe %b miso %b expected all 0",
               bus.mem_addr, bus.mem_din, bus.miso_oe, bus.miso);
    else n_pass++;
    bus.cs_n = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(8);
    write_frame("after_reset", 7'h33, 8'hC3, 16);
  endtask

  task automatic test_overclock_ignore();
    int w0, f0, o0;
    write_frame("overclock", 7'h22, 8'h96, 20);
    w0 = wren_cnt; f0 = fd_cnt; o0 = oe_cnt;
    bus.cs_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.mosi = i[0];
      wait_clks(HALF);
      bus.sclk = 1'b1;
      wait_clks(HALF);
      bus.sclk = 1'b0;
    end
    wait_clks(HALF);
    n_checks++;
    if (wren_cnt - w0 !== 0 || fd_cnt - f0 !== 0 || oe_cnt - o0 !== 0)
      $display("FAIL deselected_activity: got wren %0d fd %0d oe %0d expected 0 0 0",
               wren_cnt - w0, fd_cnt - f0, oe_cnt - o0);
    else n_pass++;
    n_checks++;
    if ({bus.mem_addr, bus.mem_din} !== {7'h22, 8'h96})
      $display("FAIL deselected_hold: got addr %h din %h expected 22 96", bus.mem_addr, bus.mem_din);
    else n_pass++;
  endtask

  initial begin
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_write_then_read();
    test_abort();
    test_reset_mid_read();
    test_overclock_ignore();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
